// File: rtl/stall_pipe_pkg.sv
// Shared defaults and width helpers for the stall/drain slice.
package stall_pipe_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int DEPTH_DEF = 4;
    localparam int PTR_W     = $clog2(DEPTH_DEF);
    localparam int LVL_W     = PTR_W + 1;

    localparam int              CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Pointer width for a power-of-two depth.
    function automatic int ptr_bits(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/drain_fifo.sv
// Output FIFO: storage, wrapping pointers and occupancy level.
module drain_fifo
    import stall_pipe_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int PW   = ptr_bits(DEPTH),
    localparam int LW   = PW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Storage write; contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    // Pointers and level; pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Head is forced to zero while empty so unreset storage never leaks out.
    always_comb begin
        pop_data = '0;
        if (level != '0) pop_data = mem[rd_ptr];
    end

    // Ordering check: each slot carries the push sequence number it was written with.
    logic [7:0] tag_mem [DEPTH];
    logic [7:0] push_seq;
    logic [7:0] pop_seq;

    // Tag storage follows the data storage.
    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_ptr] <= push_seq;
    end

    // Sequence counters for the ordering check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            push_seq <= '0;
            pop_seq  <= '0;
        end else begin
            if (push) push_seq <= push_seq + 1'b1;
            if (pop)  pop_seq  <= pop_seq + 1'b1;
        end
    end

    a_order: assert property (@(posedge clk) disable iff (!rst_n)
        pop |-> (tag_mem[rd_ptr] == pop_seq));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && level == '0));

endmodule

// File: rtl/stall_drain.sv
// Tracks a 2-stage stall pipeline and drains its results into an output FIFO,
// freezing the pipeline when the FIFO cannot take the tail result.
module stall_drain
    import stall_pipe_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int LW   = ptr_bits(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue,
    input  logic [WIDTH-1:0] in_d1,
    input  logic [WIDTH-1:0] in_d2,
    input  logic             out_ready,
    output logic             stall,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [LW-1:0]    level,
    output logic             err,
    output logic [15:0]      stall_cnt
);

    logic v0;
    logic v1;
    logic push;
    logic pop;

    // Stall is a pure function of registered state; a pop in the same cycle
    // does not release it, trading one cycle for a short timing path.
    always_comb begin
        stall     = v1 && (level == LW'(DEPTH));
        push      = v1 && !stall;
        out_valid = (level != '0);
        pop       = out_valid && out_ready;
    end

    // Pipeline occupancy mirror; frozen while stalled, so issue is dropped then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0 <= 1'b0;
            v1 <= 1'b0;
        end else if (!stall) begin
            v0 <= issue;
            v1 <= v0;
        end
    end

    // Sticky path-mismatch flag and saturating stall-cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err       <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (push && (in_d1 != in_d2)) err <= 1'b1;
            if (stall && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + 1'b1;
        end
    end

    drain_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (in_d1),
        .pop       (pop),
        .pop_data  (out_data),
        .level     (level)
    );

    a_level_max: assert property (@(posedge clk) disable iff (!rst_n)
        level <= LW'(DEPTH));
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && level == LW'(DEPTH)));
    a_stall_v1: assert property (@(posedge clk) disable iff (!rst_n)
        stall |-> v1);

endmodule

// File: tb/tb_stall_drain.sv
// Randomised and directed bench for stall_drain against a queue-based model.
module tb_stall_drain;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             issue;
    logic [WIDTH-1:0] in_d1;
    logic [WIDTH-1:0] in_d2;
    logic             out_ready;
    logic             stall;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [LW-1:0]    level;
    logic             err;
    logic [15:0]      stall_cnt;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: two pipeline slots holding (d1, d2) pairs, a result queue.
    bit          mv0, mv1;
    logic [15:0] a0, b0, a1, b1;
    logic [15:0] q[$];
    bit          merr;
    int          mcnt;

    always #5 clk = ~clk;

    stall_drain #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .issue     (issue),
        .in_d1     (in_d1),
        .in_d2     (in_d2),
        .out_ready (out_ready),
        .stall     (stall),
        .out_valid (out_valid),
        .out_data  (out_data),
        .level     (level),
        .err       (err),
        .stall_cnt (stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mv0 = 0; mv1 = 0; merr = 0; mcnt = 0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        q.delete();
    endtask

    task automatic check_outputs();
        bit exp_full;
        exp_full = mv1 && (q.size() == DEPTH);
        chk("stall",     32'(stall),     32'(exp_full));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("out_data",  32'(out_data),  (q.size() != 0) ? 32'(q[0]) : 32'd0);
        chk("level",     32'(level),     32'(q.size()));
        chk("err",       32'(err),       32'(merr));
        chk("stall_cnt", 32'(stall_cnt), 32'(mcnt));
    endtask

    // One clock cycle: drive inputs after negedge, check, advance model, cross posedge.
    task automatic cyc(input bit iss, input bit rdy, input logic [15:0] va, input logic [15:0] vb);
        bit st, pp;
        issue     = iss;
        out_ready = rdy;
        in_d1     = mv1 ? a1 : 16'($urandom);
        in_d2     = mv1 ? b1 : 16'($urandom);
        #1;
        check_outputs();
        st = mv1 && (q.size() == DEPTH);
        pp = (q.size() != 0) && rdy;
        if (pp) void'(q.pop_front());
        if (mv1 && !st) begin
            q.push_back(a1);
            if (a1 !== b1) merr = 1;
        end
        if (st && mcnt < 65535) mcnt++;
        if (!st) begin
            mv1 = mv0; a1 = a0; b1 = b0;
            mv0 = iss; a0 = va; b0 = vb;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rnd(input int n, input int pi, input int pr, input int pbad);
        logic [15:0] v;
        for (int i = 0; i < n; i++) begin
            v = 16'($urandom);
            cyc($urandom_range(99) < pi, $urandom_range(99) < pr, v,
                ($urandom_range(99) < pbad) ? (v ^ 16'h0001) : v);
        end
    endtask

    task automatic sync_reset();
        rst_n = 1'b0;
        issue = 0; out_ready = 0; in_d1 = '0; in_d2 = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        sync_reset();

        // Single result, free-flowing output
        cyc(1, 1, 16'h0030, 16'h0030);
        for (int i = 0; i < 6; i++) cyc(0, 1, 16'h0, 16'h0);

        // Fill with output blocked
        for (int i = 0; i < 8; i++) cyc(1, 0, 16'(100 + i), 16'(100 + i));
        chk("full_level", 32'(level), 32'(DEPTH));
        chk("full_stall", 32'(stall), 32'd1);

        // One pop from full, then blocked again, then a 20-item mixed run
        cyc(1, 1, 16'h00AA, 16'h00AA);
        for (int i = 0; i < 3; i++) cyc(1, 0, 16'(200 + i), 16'(200 + i));
        for (int i = 0; i < 20; i++)
            cyc(1, $urandom_range(1), 16'(300 + i), 16'(300 + i));
        for (int i = 0; i < 10; i++) cyc(0, 1, 16'h0, 16'h0);

        // Path mismatch: err is sticky, d1 value is still delivered
        cyc(1, 1, 16'h1234, 16'h1235);
        for (int i = 0; i < 6; i++) cyc(0, 1, 16'h0, 16'h0);
        chk("err_sticky", 32'(err), 32'd1);

        // Randomised traffic with occasional mismatches
        rnd(400, 60, 50, 5);
        rnd(200, 90, 20, 0);
        rnd(200, 30, 90, 0);

        // Asynchronous reset mid-cycle with level 3 and both stages occupied
        sync_reset();
        for (int i = 0; i < 5; i++) cyc(1, 0, 16'(500 + i), 16'(500 + i));
        chk("pre_rst_level", 32'(level), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_stall",     32'(stall),     32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_level",     32'(level),     32'd0);
        chk("rst_err",       32'(err),       32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 0, 16'hABCD, 16'hABCD);
        cyc(0, 0, 16'h0, 16'h0);
        cyc(0, 0, 16'h0, 16'h0);
        chk("post_rst_one", 32'(level), 32'd1);
        chk("post_rst_data", 32'(out_data), 32'h0000ABCD);
        for (int i = 0; i < 4; i++) cyc(0, 1, 16'h0, 16'h0);

        // Long stall: counter saturates without wrapping
        for (int i = 0; i < 70010; i++) cyc(1, 0, 16'h5555, 16'h5555);
        chk("stall_cnt_sat", 32'(stall_cnt), 32'h0000FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/stall_drain.md
STALL_DRAIN -- requirements
Module: stall_drain

Interface
REQ-001 Parameter WIDTH, default 16, result data width.
REQ-002 Parameter DEPTH, default 4, output FIFO entries; power of two, at least 2.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 issue  input  1  upstream presents a new a/b/c operand set to the 2-stage stall pipeline this cycle.
REQ-006 in_d1  input  WIDTH  pipeline tail result, path 1 (d1).
REQ-007 in_d2  input  WIDTH  pipeline tail result, path 2 (d2), redundant copy.
REQ-008 out_ready  input  1  downstream accepts out_data this cycle.
REQ-009 stall  output  1  freeze command driven to the pipeline stall input.
REQ-010 out_valid  output  1  FIFO non-empty.
REQ-011 out_data  output  WIDTH  FIFO head.
REQ-012 level  output  clog2(DEPTH)+1  FIFO occupancy.
REQ-013 err  output  1  sticky flag: path-1/path-2 mismatch seen.
REQ-014 stall_cnt  output  16  saturating count of cycles with stall=1.

Function
REQ-015 Block SHALL mirror pipeline occupancy in valid bits v0 (r stage) and v1 (d stage).
REQ-016 On each edge with stall=0: v0<=issue, v1<=v0; with stall=1, v0 and v1 SHALL hold.
REQ-017 issue during a stall=1 cycle SHALL be ignored; upstream is responsible for re-presenting it.
REQ-018 push SHALL be v1 & !stall; on push, in_d1 is written to the FIFO tail on that edge.
REQ-019 pop SHALL be out_valid & out_ready; head advances on that edge.
REQ-020 stall SHALL be v1 & (level==DEPTH); combinational from registers only, no path from out_ready.
REQ-021 When full with a simultaneous pop, stall SHALL still assert; conservative, loses one cycle, never drops data.
REQ-022 Push and pop in the same cycle with level<DEPTH: level unchanged, FIFO order preserved.
REQ-023 Pop when empty SHALL be impossible, since out_valid=0; push when full SHALL be impossible, since stall=1.
REQ-024 Pointers SHALL wrap modulo DEPTH; level ranges 0..DEPTH inclusive.
REQ-025 Result latency: issue accepted at edge N reaches the FIFO at edge N+2 plus stalled cycles; out_valid rises the cycle after push.
REQ-026 err SHALL set on any push with in_d1!=in_d2 and remain set until reset; the in_d1 data is still pushed.
REQ-027 stall_cnt SHALL increment each cycle stall=1 and saturate at 16'hFFFF.
REQ-028 Embedded properties SHALL check:
- level<=DEPTH
- !(push & level==DEPTH)
- stall implies v1
- FIFO data out in push order

Reset
REQ-029 rst_n=0 SHALL immediately clear v0, v1, pointers, level, err and stall_cnt.
REQ-030 During and after reset: stall=0, out_valid=0, out_data=0 and level=0.
REQ-031 Reset mid-operation SHALL discard all buffered and in-flight results; the first post-reset push is the first new result.
REQ-032 FIFO storage array need not be reset; out_data SHALL be forced 0 while empty.

Structure
REQ-033 Package stall_pipe_pkg SHALL hold WIDTH and DEPTH defaults and the PTR_W/LVL_W localparams.
REQ-034 FIFO storage and pointers SHALL be one sub-module, drain_fifo (push, pop, data, level); stall logic, valid tracking, err and stall_cnt stay in stall_drain.
REQ-035 Target size: 150-300 lines RTL in total.

Verification
REQ-036 issue=1 at cycle 0 only, in_d1=in_d2=16'h0030, out_ready=1 -> push at edge 2, out_valid=1 with out_data=0x0030 in cycle 3, level returns to 0, stall never asserts.
REQ-037 out_ready=0, issue=1 for 8 cycles, DEPTH=4 -> level reaches 4, then stall=1 with v1=1; no push while full; stall_cnt increments each stalled cycle.
REQ-038 From full, out_ready=1 for one cycle -> stall stays 1 that cycle, level=3 next cycle, stall drops, the held result is pushed, level=4; no data lost or duplicated over a 20-item sequence.
REQ-039 Push with in_d1=16'h1234, in_d2=16'h1235 -> err=1 next cycle and stays 1; 0x1234 appears on out_data.
REQ-040 rst_n pulled low asynchronously mid-cycle with level=3 and v0=v1=1 -> all outputs 0 immediately; after release, first issue yields exactly one result two edges later.
REQ-041 Hold stall for 70000 cycles -> stall_cnt saturates at 16'hFFFF without wrapping.
